// File: rtl/csoc_uart_pkg.sv
// Shared UART constants and FSM state encoding for the CSOC serial blocks.
package csoc_uart_pkg;

  localparam int CLK_HZ       = 50_000_000;
  localparam int BAUD         = 115200;
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_DATA      = 3'd2;
  localparam logic [2:0] ST_STOP      = 3'd3;
  localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

  typedef enum logic [2:0] {
    IDLE      = ST_IDLE,
    START     = ST_START,
    DATA      = ST_DATA,
    STOP      = ST_STOP,
    WAIT_IDLE = ST_WAIT_IDLE
  } uart_state_e;

endpackage

// File: rtl/csoc_uart_rx_if.sv
// Receiver -> command parser output bundle.
interface csoc_uart_rx_if;
  logic [7:0] rx_data_o;
  logic       new_rx_data_o;
  logic       frame_err_o;
  logic       busy_o;

  modport master (output rx_data_o, new_rx_data_o, frame_err_o, busy_o);
  modport slave  (input  rx_data_o, new_rx_data_o, frame_err_o, busy_o);
endinterface

// File: rtl/csoc_uart_rx_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic meta_q, sync_q;

  // Two back-to-back flops; reset to the pin's idle level.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/csoc_uart_rx.sv
// 8N1 UART receiver: start-glitch rejection, framing-error flag, one-cycle byte strobe.
module csoc_uart_rx #(
  parameter int CLKS_PER_BIT = csoc_uart_pkg::CLKS_PER_BIT
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  rx_i,
  csoc_uart_rx_if.master        bus
);
  import csoc_uart_pkg::*;

  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int HALF = CLKS_PER_BIT / 2;

  logic              rxs;
  uart_state_e       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shreg_q, shreg_d;
  logic [7:0]        data_q, data_d;
  logic              pend_q, pend_d;   // good stop bit seen; publish byte next cycle
  logic              new_q, new_d;
  logic              fe_q, fe_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d_i  (rx_i),
    .q_o  (rxs)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      data_q  <= '0;
      pend_q  <= 1'b0;
      new_q   <= 1'b0;
      fe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
      new_q   <= new_d;
      fe_q    <= fe_d;
    end
  end

  // Next-state, bit sampling and output pulse generation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    pend_d  = 1'b0;
    new_d   = pend_q;
    fe_d    = 1'b0;

    // Shift register is stable here: DATA cannot be re-entered this soon.
    if (pend_q) data_d = shreg_q;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rxs) state_d = START;
      end
      START: begin
        if (cnt_q == CW'(HALF - 1)) begin
          cnt_d = '0;
          bit_d = '0;
          state_d = rxs ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d          = '0;
          shreg_d[bit_q] = rxs;
          bit_d          = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Leaving mid stop bit lets an immediately following start bit be seen.
        if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
          cnt_d = '0;
          if (rxs) begin
            pend_d  = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        // Absorb a break so it yields one error and no phantom bytes.
        cnt_d = '0;
        if (rxs) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rx_data_o     = data_q;
  assign bus.new_rx_data_o = new_q;
  assign bus.frame_err_o   = fe_q;
  assign bus.busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_csoc_uart_rx.sv
// Directed bench for csoc_uart_rx at CLKS_PER_BIT=8 (10 ns clock, 80 ns bit).
`timescale 1ns/100ps
module tb_csoc_uart_rx;

  localparam int CPB = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic rx   = 1'b1;

  csoc_uart_rx_if bus();

  csoc_uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk  (clk),
    .rstn (rstn),
    .rx_i (rx),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  int n_new = 0, n_fe = 0, n_both = 0;
  int last_cyc = 0;
  int t_start = 0;
  int pulse_cyc[$];
  logic [7:0] pulse_dat[$];

  // Pulse monitor, sampled away from the active edge.
  always @(negedge clk) begin
    if (bus.new_rx_data_o) begin
      n_new++;
      last_cyc = cyc;
      pulse_cyc.push_back(cyc);
      pulse_dat.push_back(bus.rx_data_o);
    end
    if (bus.frame_err_o) n_fe++;
    if (bus.new_rx_data_o && bus.frame_err_o) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame; stop_v lets the stop bit be forced low.
  task automatic send(input logic [7:0] b, input logic stop_v, input real bit_ns);
    t_start = cyc;
    rx = 1'b0;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(bit_ns);
    end
    rx = stop_v;
    #(bit_ns);
  endtask

  int nn, nf;

  initial begin
    // reset state
    idle(3);
    chk("rst_data", bus.rx_data_o, 0);
    chk("rst_new",  bus.new_rx_data_o, 0);
    chk("rst_fe",   bus.frame_err_o, 0);
    chk("rst_busy", bus.busy_o, 0);
    rstn = 1'b1;
    idle(5);

    // 1: single byte, latency 79 cycles after first low sample
    nn = n_new; nf = n_fe;
    send(8'h72, 1'b1, 80.0);
    idle(10);
    chk("t1_cnt",  n_new - nn, 1);
    chk("t1_lat",  last_cyc - t_start, 80);
    chk("t1_data", bus.rx_data_o, 8'h72);
    chk("t1_fe",   n_fe - nf, 0);

    // 2: 3-cycle start glitch is dropped
    nn = n_new;
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(10);
    chk("t2_busy",  bus.busy_o, 0);
    chk("t2_nopls", n_new - nn, 0);
    chk("t2_keep",  bus.rx_data_o, 8'h72);
    send(8'h65, 1'b1, 80.0);
    idle(10);
    chk("t2_data", bus.rx_data_o, 8'h65);
    chk("t2_cnt",  n_new - nn, 1);

    // 3: bad stop bit followed by a break
    nn = n_new; nf = n_fe;
    send(8'h73, 1'b0, 80.0);
    idle(40);
    chk("t3_busy_brk", bus.busy_o, 1);
    rx = 1'b1;
    idle(10);
    chk("t3_fe",   n_fe - nf, 1);
    chk("t3_nonew", n_new - nn, 0);
    chk("t3_keep", bus.rx_data_o, 8'h65);
    send(8'h67, 1'b1, 80.0);
    idle(10);
    chk("t3_data", bus.rx_data_o, 8'h67);

    // 4: back-to-back frames
    pulse_cyc.delete();
    pulse_dat.delete();
    send(8'h73, 1'b1, 80.0);
    send(8'h65, 1'b1, 80.0);
    send(8'h69, 1'b1, 80.0);
    idle(10);
    chk("t4_cnt", pulse_cyc.size(), 3);
    if (pulse_cyc.size() == 3) begin
      chk("t4_gap0", pulse_cyc[1] - pulse_cyc[0], 80);
      chk("t4_gap1", pulse_cyc[2] - pulse_cyc[1], 80);
      chk("t4_d0",   pulse_dat[0], 8'h73);
      chk("t4_d1",   pulse_dat[1], 8'h65);
      chk("t4_d2",   pulse_dat[2], 8'h69);
    end

    // 5: reset in the middle of bit 4 of 0xFF
    nn = n_new;
    fork
      send(8'hFF, 1'b1, 80.0);
      begin
        #(44 * 10);
        rstn = 1'b0;
        #1;
        chk("t5_data", bus.rx_data_o, 0);
        chk("t5_busy", bus.busy_o, 0);
        chk("t5_new",  bus.new_rx_data_o, 0);
        #30;
        rstn = 1'b1;
      end
    join
    idle(20);
    chk("t5_nopls", n_new - nn, 0);
    send(8'h0F, 1'b1, 80.0);
    idle(10);
    chk("t5_data2", bus.rx_data_o, 8'h0F);
    chk("t5_cnt",   n_new - nn, 1);

    // 6: +/-3% bit period
    nn = n_new; nf = n_fe;
    send(8'hA5, 1'b1, 82.4);
    idle(10);
    chk("t6_fast_data", bus.rx_data_o, 8'hA5);
    chk("t6_fast_cnt",  n_new - nn, 1);
    nn = n_new;
    send(8'hA5, 1'b1, 77.6);
    idle(10);
    chk("t6_slow_data", bus.rx_data_o, 8'hA5);
    chk("t6_slow_cnt",  n_new - nn, 1);
    chk("t6_fe",        n_fe - nf, 0);

    chk("excl", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/csoc_uart_rx.md
Name: csoc_uart_rx

Overview:
- UART receiver feeding the CSOC test command parser.
- Turns the asynchronous serial line from the host (8N1, LSB first) into byte-wide data plus a one-cycle strobe.
- Its outputs drive the parser's rx_data / new_rx_data inputs directly.
- Rejects start-bit glitches and flags framing errors, so a noisy line cannot inject spurious commands ("r", "s", "e", ...).

Parameters:
- CLKS_PER_BIT, 434, clk cycles per bit (50 MHz / 115200); legal range >= 4; counter width = $clog2(CLKS_PER_BIT).

Ports:
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- rx_i  in  1  serial line, asynchronous to clk, idle high.
- rx_data_o  out  8  last correctly framed byte; held until the next good byte.
- new_rx_data_o  out  1  one-cycle pulse: rx_data_o was updated this cycle.
- frame_err_o  out  1  one-cycle pulse: stop bit sampled low.
- busy_o  out  1  high in every state except IDLE.

Behaviour:
- Reset (async, rstn=0):
  - rx_data_o=0x00, new_rx_data_o=0, frame_err_o=0, busy_o=0.
  - State=IDLE, bit/clk counters=0, shift register=0.
  - Both synchroniser flops reset to 1 (idle line).
  - A reset during a byte discards it: no pulse, rx_data_o=0.
- Synchroniser: rx_i passes through 2 flops; the FSM only uses the stage-2 output, rxs.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE.
- IDLE: on rxs==0, go to START and clear the clk counter.
- START:
  - Count to HALF-1, where HALF = CLKS_PER_BIT/2 (floor).
  - At that count, sample rxs.
  - rxs==0: go to DATA, clear the clk counter and bit index.
  - rxs==1: glitch; go to IDLE with no output activity.
- DATA:
  - Every CLKS_PER_BIT cycles (count==CLKS_PER_BIT-1), sample rxs into shift register bit [bit_idx], LSB first.
  - Increment bit_idx (3 bits); after bit 7, go to STOP.
- STOP:
  - After CLKS_PER_BIT cycles, sample rxs.
  - rxs==1: in the next cycle rx_data_o <= shift register and new_rx_data_o=1 for exactly 1 cycle; go to IDLE.
  - rxs==0: frame_err_o=1 for 1 cycle; rx_data_o unchanged; go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until rxs==1, then go to IDLE.
  - A break (line held low) therefore produces exactly one frame_err and no phantom bytes.
- Latency:
  - Let cycle 0 be the clk edge at which rx_i is first sampled 0 by sync stage 1.
  - new_rx_data_o is high in cycle HALF + 9*CLKS_PER_BIT + 3.
  - For CLKS_PER_BIT=8 this is cycle 79.
- Back-to-back bytes:
  - Return to IDLE happens mid stop bit, so a start bit immediately following one stop bit is detected.
  - No minimum idle time is required.
- Mutual exclusion: new_rx_data_o and frame_err_o are never high in the same cycle; at most one of them pulses per frame.
- Consumer has no back-pressure: the parser must take the byte in the pulse cycle; rx_data_o stays stable until the next pulse.
- Counters saturate nowhere. Every counter clear is explicit on state entry, so there is no wrap-around dependency.

Decomposition:
- Package csoc_uart_pkg holds:
  - Constants CLK_HZ=50_000_000, BAUD=115200, CLKS_PER_BIT = CLK_HZ/BAUD.
  - The FSM state encoding (3-bit localparams).
  - These are shared with the future csoc_uart_tx.
- Sub-module sync_2ff (parameter RESET_VAL) for the input synchroniser, reusable for other async CSOC pins.

Test Plan (bench CLKS_PER_BIT=8):
1. Drive 0x72 ("r") as 8N1 → exactly one new_rx_data_o pulse at cycle 79, with rx_data_o=0x72; frame_err_o stays 0.
2. Low glitch of 3 cycles on idle line → no pulse, busy_o returns to 0; then 0x65 → rx_data_o=0x65.
3. Send 0x73 with stop bit forced 0, then hold the line low for 40 cycles → exactly one frame_err_o pulse, no new_rx_data_o, rx_data_o keeps its previous value; line high, then 0x67 → rx_data_o=0x67.
4. Back-to-back 0x73, 0x65, 0x69 with one stop bit each, no idle gap → three pulses 80 cycles apart carrying 0x73, 0x65, 0x69.
5. Assert rstn low mid-way through bit 4 of 0xFF → outputs immediately 0; after release, no pulse for the truncated frame; next 0x0F received correctly.
6. Bit-rate tolerance: transmit 0xA5 at +3% and -3% bit period → received as 0xA5 with no frame error.
